// File: rtl/axil_word_master.sv
// Word-to-line bridge: one 32-bit core load/store becomes one 128-bit
// AXI-Lite read or strobed write to the line-wide SRAM slave.
module axil_word_master #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] readAddr_addr,
  output logic              readAddr_valid,
  input  logic              readAddr_ready,
  input  logic [127:0]      readData_data,
  input  logic              readData_valid,
  output logic              readData_ready,
  output logic [ADDR_W-1:0] writeAddr_addr,
  output logic              writeAddr_valid,
  input  logic              writeAddr_ready,
  output logic [127:0]      writeData_data,
  output logic [15:0]       writeData_strb,
  output logic              writeData_valid,
  input  logic              writeData_ready,
  input  logic [31:0]       writeResp_msg,
  input  logic              writeResp_valid,
  output logic              writeResp_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WREQ,
    S_WRESP,
    S_RSP
  } state_e;

  state_e state_q, state_d;

  logic [1:0]        lane_q, lane_d;
  logic              req_ready_q, req_ready_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic              ar_valid_q, ar_valid_d;
  logic              r_ready_q, r_ready_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              aw_valid_q, aw_valid_d;
  logic [127:0]      w_data_q, w_data_d;
  logic [15:0]       w_strb_q, w_strb_d;
  logic              w_valid_q, w_valid_d;
  logic              b_ready_q, b_ready_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept;
  logic              ar_hs;
  logic              r_hs;
  logic              aw_hs;
  logic              w_hs;
  logic              b_hs;
  logic              rsp_hs;
  logic [ADDR_W-1:0] line_addr;

  // Word-offset bits carry no information for a line access.
  logic unused_addr_lo;
  assign unused_addr_lo = ^req_addr[1:0];

  assign accept    = req_valid & req_ready_q;
  assign ar_hs     = ar_valid_q & readAddr_ready;
  assign r_hs      = r_ready_q & readData_valid;
  assign aw_hs     = aw_valid_q & writeAddr_ready;
  assign w_hs      = w_valid_q & writeData_ready;
  assign b_hs      = b_ready_q & writeResp_valid;
  assign rsp_hs    = rsp_valid_q & rsp_ready;
  assign line_addr = {req_addr[ADDR_W-1:4], 4'b0000};

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    ar_addr_d   = ar_addr_q;
    aw_addr_d   = aw_addr_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          lane_d = req_addr[3:2];
          if (req_we) begin
            aw_addr_d = line_addr;
            w_data_d  = {4{req_wdata}};
            w_strb_d  = {12'h000, req_wmask}
                        << {req_addr[3:2], 2'b00};
            state_d   = S_WREQ;
          end else begin
            ar_addr_d = line_addr;
            state_d   = S_RADDR;
          end
        end
      end
      S_RADDR: begin
        if (ar_hs) state_d = S_RDATA;
      end
      S_RDATA: begin
        if (r_hs) begin
          rsp_rdata_d = readData_data[{lane_q, 5'b00000} +: 32];
          rsp_err_d   = 1'b0;
          state_d     = S_RSP;
        end
      end
      S_WREQ: begin
        // Same-cycle address and data handshakes both count here.
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) state_d = S_WRESP;
      end
      S_WRESP: begin
        if (b_hs) begin
          rsp_rdata_d = 32'h0;
          rsp_err_d   = |writeResp_msg;
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_hs) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake controls are registered from the next state.
    req_ready_d = (state_d == S_IDLE);
    ar_valid_d  = (state_d == S_RADDR);
    r_ready_d   = (state_d == S_RDATA);
    aw_valid_d  = (state_d == S_WREQ) & ~aw_done_d;
    w_valid_d   = (state_d == S_WREQ) & ~w_done_d;
    b_ready_d   = (state_d == S_WRESP);
    rsp_valid_d = (state_d == S_RSP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lane_q      <= 2'b00;
      req_ready_q <= 1'b1;
      ar_addr_q   <= '0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      aw_addr_q   <= '0;
      aw_valid_q  <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      req_ready_q <= req_ready_d;
      ar_addr_q   <= ar_addr_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      aw_addr_q   <= aw_addr_d;
      aw_valid_q  <= aw_valid_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      w_valid_q   <= w_valid_d;
      b_ready_q   <= b_ready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign readAddr_addr   = ar_addr_q;
  assign readAddr_valid  = ar_valid_q;
  assign readData_ready  = r_ready_q;
  assign writeAddr_addr  = aw_addr_q;
  assign writeAddr_valid = aw_valid_q;
  assign writeData_data  = w_data_q;
  assign writeData_strb  = w_strb_q;
  assign writeData_valid = w_valid_q;
  assign writeResp_ready = b_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_err         = rsp_err_q;

endmodule

// File: tb/tb_axil_word_master.sv
// Directed bench for axil_word_master with a small 128-bit SRAM
// slave model; expected values are hand-computed constants.
module tb_axil_word_master;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [3:0]   req_wmask;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [31:0]  readAddr_addr;
  logic         readAddr_valid;
  logic         readAddr_ready;
  logic [127:0] readData_data;
  logic         readData_valid;
  logic         readData_ready;
  logic [31:0]  writeAddr_addr;
  logic         writeAddr_valid;
  logic         writeAddr_ready;
  logic [127:0] writeData_data;
  logic [15:0]  writeData_strb;
  logic         writeData_valid;
  logic         writeData_ready;
  logic [31:0]  writeResp_msg;
  logic         writeResp_valid;
  logic         writeResp_ready;

  always #5 clk = ~clk;

  axil_word_master #(.ADDR_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_wmask       (req_wmask),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .readAddr_addr   (readAddr_addr),
    .readAddr_valid  (readAddr_valid),
    .readAddr_ready  (readAddr_ready),
    .readData_data   (readData_data),
    .readData_valid  (readData_valid),
    .readData_ready  (readData_ready),
    .writeAddr_addr  (writeAddr_addr),
    .writeAddr_valid (writeAddr_valid),
    .writeAddr_ready (writeAddr_ready),
    .writeData_data  (writeData_data),
    .writeData_strb  (writeData_strb),
    .writeData_valid (writeData_valid),
    .writeData_ready (writeData_ready),
    .writeResp_msg   (writeResp_msg),
    .writeResp_valid (writeResp_valid),
    .writeResp_ready (writeResp_ready)
  );

  // SRAM slave model
  logic [127:0] mem [16];
  logic         rpend;
  logic [127:0] rdat;
  logic         aw_got, w_got, wr_go, bval;
  logic [31:0]  aw_a;
  logic [127:0] w_d;
  logic [15:0]  w_s;
  logic         wr_en;
  logic         rd_stall;
  logic [31:0]  bmsg;
  int           rd_count = 0;
  int           wr_count = 0;
  int           cyc = 0;

  assign readAddr_ready  = 1'b1;
  assign writeAddr_ready = 1'b1;
  assign writeData_ready = wr_en;
  assign readData_valid  = rpend & ~rd_stall;
  assign readData_data   = rdat;
  assign writeResp_valid = bval;
  assign writeResp_msg   = bmsg;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rpend  <= 1'b0;
      rdat   <= '0;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      wr_go  <= 1'b0;
      bval   <= 1'b0;
      aw_a   <= '0;
      w_d    <= '0;
      w_s    <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[3] <= 128'h3F3E3D3C_3B3A3938_37363534_33323130;
      mem[4] <= 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    end else begin
      if (readAddr_valid && readAddr_ready) begin
        rpend    <= 1'b1;
        rdat     <= mem[readAddr_addr[7:4]];
        rd_count <= rd_count + 1;
      end else if (readData_valid && readData_ready) begin
        rpend <= 1'b0;
      end
      if (writeAddr_valid && writeAddr_ready) begin
        aw_got <= 1'b1;
        aw_a   <= writeAddr_addr;
      end
      if (writeData_valid && writeData_ready) begin
        w_got <= 1'b1;
        w_d   <= writeData_data;
        w_s   <= writeData_strb;
      end
      if ((aw_got || (writeAddr_valid && writeAddr_ready)) &&
          (w_got || (writeData_valid && writeData_ready)) &&
          !wr_go && !bval)
        wr_go <= 1'b1;
      if (wr_go) begin
        for (int b = 0; b < 16; b++)
          if (w_s[b]) mem[aw_a[7:4]][8*b +: 8] <= w_d[8*b +: 8];
        wr_count <= wr_count + 1;
        wr_go    <= 1'b0;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
        bval     <= 1'b1;
      end else if (bval && writeResp_ready) begin
        bval <= 1'b0;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int acc   = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input string tag, input logic we,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc       = cyc;
  endtask

  task automatic wait_rsp(input string tag, output logic [31:0] rd,
                          output logic er, output int lat);
    lat = -1;
    rd  = '0;
    er  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid && rsp_ready) begin
        rd  = rsp_rdata;
        er  = rsp_err;
        lat = cyc - acc + 1;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (lat < 0) chk({tag, "_rsp_timeout"}, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected end");
    $fatal(1);
  end

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          base;
  logic        seen;

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
    rsp_ready = 1'b1;
    wr_en     = 1'b1;
    rd_stall  = 1'b0;
    bmsg      = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    chk("rst_ctl",
        {req_ready, rsp_valid, readAddr_valid, readData_ready,
         writeAddr_valid, writeData_valid, writeResp_ready},
        7'b1000000);
    chk("rst_rsp", {rsp_rdata, rsp_err}, 33'h0);
    chk("rst_payload",
        {readAddr_addr, writeAddr_addr, writeData_strb}, 80'h0);
    chk("rst_wdata", writeData_data, 128'h0);
    @(posedge clk);
    #1;

    // load lane 2 of line 0x40
    issue("ld48", 1'b0, 32'h48, 32'h0, 4'h0);
    chk("ld48_ar", {readAddr_valid, readAddr_addr}, {1'b1, 32'h40});
    wait_rsp("ld48", rd, er, lat);
    chk("ld48_rdata", rd, 32'h0B0A0908);
    chk("ld48_err", er, 1'b0);
    chk("ld48_lat", lat, 3);
    chk("ld48_idle", req_ready, 1'b1);

    // strobed store to lane 1
    base = wr_count;
    issue("st34", 1'b1, 32'h34, 32'hDEADBEEF, 4'b0110);
    chk("st34_valids", {writeAddr_valid, writeData_valid}, 2'b11);
    chk("st34_awaddr", writeAddr_addr, 32'h30);
    chk("st34_strb", writeData_strb, 16'h0060);
    chk("st34_wdata", writeData_data, {4{32'hDEADBEEF}});
    wait_rsp("st34", rd, er, lat);
    chk("st34_lat", lat, 4);
    chk("st34_rsp", {er, rd}, 33'h0);
    chk("st34_writes", wr_count - base, 1);
    issue("rb34", 1'b0, 32'h34, 32'h0, 4'h0);
    wait_rsp("rb34", rd, er, lat);
    chk("rb34_rdata", rd, 32'h37ADBE34);

    // split write handshake
    base  = wr_count;
    wr_en = 1'b0;
    issue("st24", 1'b1, 32'h24, 32'h11223344, 4'hF);
    chk("st24_c1", {writeAddr_valid, writeData_valid}, 2'b11);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("st24_hold", {writeAddr_valid, writeData_valid}, 2'b01);
      chk("st24_wstable", writeData_data, {4{32'h11223344}});
      chk("st24_sstable", writeData_strb, 16'h00F0);
    end
    wr_en = 1'b1;
    wait_rsp("st24", rd, er, lat);
    chk("st24_rsp", {er, rd}, 33'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("st24_writes", wr_count - base, 1);
    issue("rb24", 1'b0, 32'h24, 32'h0, 4'h0);
    wait_rsp("rb24", rd, er, lat);
    chk("rb24_rdata", rd, 32'h11223344);

    // response backpressure
    base      = rd_count;
    rsp_ready = 1'b0;
    issue("bp", 1'b0, 32'h48, 32'h0, 4'h0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (rsp_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("bp_rsp_seen", seen, 1'b1);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h34;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", {rsp_valid, req_ready, rsp_err}, 3'b100);
      chk("bp_rdata", rsp_rdata, 32'h0B0A0908);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_done", {rsp_valid, req_ready}, 2'b01);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_accept", readAddr_valid, 1'b0);
    chk("bp_reads", rd_count - base, 1);

    // write error response
    bmsg = 32'h1;
    issue("werr", 1'b1, 32'h00, 32'hCAFEF00D, 4'hF);
    wait_rsp("werr", rd, er, lat);
    chk("werr_err", er, 1'b1);
    chk("werr_rdata", rd, 32'h0);
    bmsg = 32'h0;
    issue("ld_after", 1'b0, 32'h48, 32'h0, 4'h0);
    wait_rsp("ld_after", rd, er, lat);
    chk("ld_after_err", er, 1'b0);
    chk("ld_after_rdata", rd, 32'h0B0A0908);

    // reset during read-data wait
    rd_stall = 1'b1;
    issue("rstop", 1'b0, 32'h40, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    chk("rstop_rdata_wait", readData_ready, 1'b1);
    rst = 1'b1;
    #1;
    chk("rstop_async",
        {req_ready, rsp_valid, readAddr_valid, readData_ready,
         writeAddr_valid, writeData_valid, writeResp_ready},
        7'b1000000);
    @(posedge clk);
    #1;
    chk("rstop_edge",
        {req_ready, rsp_valid, readAddr_valid, readData_ready},
        4'b1000);
    rst      = 1'b0;
    rd_stall = 1'b0;
    seen     = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      seen = seen | rsp_valid;
    end
    chk("rstop_no_rsp", seen, 1'b0);
    issue("ld40", 1'b0, 32'h40, 32'h0, 4'h0);
    wait_rsp("ld40", rd, er, lat);
    chk("ld40_rdata", rd, 32'h03020100);
    chk("ld40_lat", lat, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axil_word_master.md
# axil_word_master

Word-to-line bridge and AXI-Lite master placed directly upstream of the 128-bit on-chip SRAM slave. It accepts single 32-bit load/store requests from the core's memory port and issues one 128-bit AXI-Lite read or strobed write to the SRAM. It then returns the addressed 32-bit word, or a write completion, on a response handshake. Only one transaction is outstanding at a time.

## Interface
Parameters
- ADDR_W, 32, core and AXI address width
- (no others; line width fixed at 128 bits / 16 bytes, word 32 bits)

Ports
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  bridge can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address; bits [1:0] ignored
- req_wdata  in  32  store data
- req_wmask  in  4  store byte enables
- rsp_valid  out  1  response valid
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  load data (0 for stores)
- rsp_err  out  1  1 = store response message non-zero
- readAddr_addr  out  32  line address
- readAddr_valid  out  1
- readAddr_ready  in  1
- readData_data  in  128
- readData_valid  in  1
- readData_ready  out  1
- writeAddr_addr  out  32  line address
- writeAddr_valid  out  1
- writeAddr_ready  in  1
- writeData_data  out  128
- writeData_strb  out  16
- writeData_valid  out  1
- writeData_ready  in  1
- writeResp_msg  in  32
- writeResp_valid  in  1
- writeResp_ready  out  1

## Operation
- Request capture: when req_valid & req_ready, register addr, we, wdata, wmask. Line address = {req_addr[31:4], 4'b0}. Lane = req_addr[3:2].
- Write formatting: writeData_data = req_wdata replicated in all 4 lanes. writeData_strb = req_wmask << (4*lane), with other bits 0.
- Read extraction: rsp_rdata = readData_data[32*lane+31 : 32*lane], captured on the read-data handshake.
- FSM states:
  - IDLE: req_ready=1. On accept, go to RADDR if load, WREQ if store.
  - RADDR: readAddr_valid=1. On readAddr_ready, go to RDATA.
  - RDATA: readData_ready=1. On readData_valid, capture the word, set rsp_err=0, go to RSP.
  - WREQ: writeAddr_valid=~aw_done and writeData_valid=~w_done. Each of aw_done/w_done sets on its own handshake. Go to WRESP in the cycle both are done, counting handshakes that complete in the same cycle.
  - WRESP: writeResp_ready=1. On writeResp_valid, set rsp_err=(writeResp_msg!=0), set rsp_rdata=0, go to RSP.
  - RSP: rsp_valid=1. On rsp_ready, go to IDLE and clear aw_done/w_done.
- AXI rules:
  - A valid, once raised, holds its payload constant until its ready is seen.
  - Valids never depend combinationally on readies.
  - Address and data payloads are driven from registers only.
- Simultaneous write-address and write-data ready in the same cycle: both handshakes complete, and the FSM goes directly to WRESP.
- req_valid outside IDLE is ignored (req_ready=0). The core must hold the request.

## Timing
- Reset values: state IDLE, req_ready=1, all AXI valids/readies 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, aw_done=w_done=0, all address/data/strb outputs 0.
- Reset mid-transaction: immediate return to IDLE. The in-flight transaction is dropped and no response is issued.
- Load, zero-wait slave: accept at cycle 0; RADDR handshake at cycle 1; SRAM readData_valid at cycle 2, RDATA handshake; rsp_valid at cycle 3. Minimum 4 cycles request-to-IDLE with rsp_ready tied high.
- Store, zero-wait slave: accept at cycle 0; both handshakes at cycle 1; writeResp_valid at cycle 3 (slave write cycle 2); rsp_valid at cycle 4.
- Back-to-back: the next request is accepted in the cycle after the rsp handshake (IDLE), never in the same cycle.
- rsp_rdata and rsp_err are stable while rsp_valid=1.

## Test plan
- Load lane: preload SRAM line 0x0040 with bytes 0x00..0x0F, request load addr 0x0048 -> readAddr_addr=0x40, rsp_rdata=0x0B0A0908, rsp_valid at cycle 3.
- Store strobe: store addr 0x0034, wdata 0xDEADBEEF, mask 4'b0110 -> writeData_strb=16'h0060, lane-1 bytes 0x35=0xBE and 0x36=0xAD written; readback of 0x0034 returns 0xXXADBEXX with old bytes intact.
- Split write handshake: slave holds writeData_ready low 3 cycles after writeAddr_ready -> writeAddr_valid drops after 1 handshake, writeData_valid held with stable payload, exactly one write, rsp after writeResp.
- Backpressure: rsp_ready low 5 cycles on a load -> rsp_valid/rsp_rdata stable; req_ready=0 throughout; new req_valid not accepted.
- Write error: writeResp_msg=0x1 -> rsp_err=1, rsp_rdata=0; next load reports rsp_err=0.
- Reset mid-op: assert rst during RDATA -> all valids 0 and req_ready=1 next edge; no rsp_valid; subsequent load completes normally.
